// File: rtl/dm_access_pkg.sv
// Shared types and codes for the data-memory access unit.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package dm_access_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } dm_state_e;

  // RV32 width/sign codes; store codes alias the signed load codes.
  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;

  localparam logic [1:0] ERR_OK       = 2'b00;
  localparam logic [1:0] ERR_MISALIGN = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b10;
  localparam logic [1:0] ERR_ILLEGAL  = 2'b11;

endpackage

// File: rtl/dm_lane_align.sv
// Byte-lane alignment: legality flags, store mask/data replication, load extract/extend.
// Latency: purely combinational.
// Backpressure: none; outputs track inputs.
module dm_lane_align
  import dm_access_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic        wr_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  output logic        illegal_o,
  output logic        misalign_o,
  output logic [3:0]  mask_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Decode access width, lane placement and load extension from funct3.
  always_comb begin
    illegal_o  = 1'b0;
    misalign_o = 1'b0;
    mask_o     = 4'b0000;
    wdata_o    = 32'h0;
    rdata_o    = 32'h0;
    byte_sel   = rdata_i[{addr_lo_i, 3'b000} +: 8];
    half_sel   = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    case (funct3_i)
      LB: begin
        mask_o  = 4'b0001 << addr_lo_i;
        wdata_o = {4{wdata_i[7:0]}};
        rdata_o = {{24{byte_sel[7]}}, byte_sel};
      end
      LH: begin
        misalign_o = addr_lo_i[0];
        mask_o     = 4'b0011 << addr_lo_i;
        wdata_o    = {2{wdata_i[15:0]}};
        rdata_o    = {{16{half_sel[15]}}, half_sel};
      end
      LW: begin
        misalign_o = |addr_lo_i;
        mask_o     = 4'b1111;
        wdata_o    = wdata_i;
        rdata_o    = rdata_i;
      end
      LBU: begin
        // Unsigned variants exist only for loads.
        illegal_o = wr_i;
        mask_o    = 4'b0001 << addr_lo_i;
        rdata_o   = {24'h0, byte_sel};
      end
      LHU: begin
        illegal_o  = wr_i;
        misalign_o = addr_lo_i[0];
        mask_o     = 4'b0011 << addr_lo_i;
        rdata_o    = {16'h0, half_sel};
      end
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/dm_access_unit.sv
// Data-memory initiator: one load/store at a time, aligned data, error codes back to pipe.
// Latency: 3 cycles accept-to-response (1 for rejected requests, TIMEOUT+2 on timeout).
// Backpressure: req_ready only in IDLE; the memory is waited on via dm_valid with a timeout.
module dm_access_unit
  import dm_access_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wr,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [1:0]  rsp_err,
  output logic [31:0] rsp_rdata,
  output logic        dm_cs,
  output logic        dm_wr,
  output logic [3:0]  dm_mask,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_data_wr,
  output logic        dm_stall,
  input  logic        dm_valid,
  input  logic [31:0] dm_data_rd
);

  localparam int CW = $clog2(TIMEOUT + 1);

  dm_state_e   state_q, state_d;
  logic        wr_q;
  logic [2:0]  funct3_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [1:0]  err_q, err_d;
  logic [31:0] rdata_q, rdata_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic        idle;
  logic        al_illegal, al_misalign;
  logic [3:0]  al_mask;
  logic [31:0] al_wdata, al_rdata;

  // In IDLE the aligner classifies the incoming request; afterwards it works on the held one.
  assign idle = (state_q == IDLE);

  dm_lane_align u_align (
    .funct3_i   (idle ? req_funct3     : funct3_q),
    .wr_i       (idle ? req_wr         : wr_q),
    .addr_lo_i  (idle ? req_addr[1:0]  : addr_q[1:0]),
    .wdata_i    (idle ? req_wdata      : wdata_q),
    .rdata_i    (dm_data_rd),
    .illegal_o  (al_illegal),
    .misalign_o (al_misalign),
    .mask_o     (al_mask),
    .wdata_o    (al_wdata),
    .rdata_o    (al_rdata)
  );

  // State, counter and response registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      err_q   <= ERR_OK;
      rdata_q <= 32'h0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
    end
  end

  // Request is held from acceptance until the response retires.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q     <= 1'b0;
      funct3_q <= 3'b000;
      addr_q   <= 32'h0;
      wdata_q  <= 32'h0;
    end else if (req_valid && req_ready) begin
      wr_q     <= req_wr;
      funct3_q <= req_funct3;
      addr_q   <= req_addr;
      wdata_q  <= req_wdata;
    end
  end

  // Next-state logic and memory/pipeline handshake outputs.
  always_comb begin
    state_d    = state_q;
    err_d      = err_q;
    rdata_d    = rdata_q;
    cnt_d      = cnt_q;
    req_ready  = 1'b0;
    rsp_valid  = 1'b0;
    dm_cs      = 1'b1;
    dm_wr      = 1'b1;
    dm_mask    = 4'b0000;
    dm_addr    = 32'h0;
    dm_data_wr = 32'h0;
    dm_stall   = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          rdata_d = 32'h0;
          if (al_illegal) begin
            err_d   = ERR_ILLEGAL;
            state_d = RESP;
          end else if (al_misalign) begin
            err_d   = ERR_MISALIGN;
            state_d = RESP;
          end else begin
            err_d   = ERR_OK;
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        // The only cycle with cs low and wr low for stores; memory writes on its negedge.
        dm_cs      = 1'b0;
        dm_wr      = ~wr_q;
        dm_stall   = 1'b1;
        dm_addr    = {2'b00, addr_q[31:2]};
        dm_mask    = al_mask;
        dm_data_wr = wr_q ? al_wdata : 32'h0;
        cnt_d      = '0;
        state_d    = WAIT;
      end
      WAIT: begin
        // Loads keep cs low because the read word is gated by it.
        dm_cs      = wr_q;
        dm_addr    = {2'b00, addr_q[31:2]};
        dm_mask    = al_mask;
        dm_data_wr = wr_q ? al_wdata : 32'h0;
        if (dm_valid) begin
          err_d   = ERR_OK;
          rdata_d = wr_q ? 32'h0 : al_rdata;
          state_d = RESP;
        end else if (cnt_q + CW'(1) == CW'(TIMEOUT)) begin
          err_d   = ERR_TIMEOUT;
          rdata_d = 32'h0;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RESP: begin
        rsp_valid = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign rsp_err   = rsp_valid ? err_q   : ERR_OK;
  assign rsp_rdata = rsp_valid ? rdata_q : 32'h0;

endmodule

// File: doc/dm_access_unit.md
# dm_access_unit

Initiator side of the data-memory port: accepts one load/store request at a time from the memory stage, drives the memory's chip-select, write strobe, byte mask, word address and write data, raises the memory stall request, and waits for the memory's valid bit. It returns aligned, sign- or zero-extended load data, or an error code, to the pipeline. It sits between the memory/writeback stage and the data memory and owns all byte-lane alignment.

## Interface
- TIMEOUT, 16: maximum WAIT cycles without dm_valid before aborting.
- clk  in  1  system clock; all flops on posedge.
- rst  in  1  reset, asynchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request; high only in IDLE.
- req_wr  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV32 width/sign code.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, LSB-justified.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_err  out  2  00 ok, 01 misaligned, 10 timeout, 11 illegal funct3.
- rsp_rdata  out  32  extended load data; 0 for stores and errors.
- dm_cs  out  1  chip select, active-low.
- dm_wr  out  1  0 = write, 1 = read.
- dm_mask  out  4  byte-lane enables.
- dm_addr  out  32  word index, req_addr[31:2] zero-extended.
- dm_data_wr  out  32  lane-replicated store data.
- dm_stall  out  1  stall request to the memory (its Stall_MW_DM).
- dm_valid  in  1  memory valid bit, registered one cycle after dm_stall.
- dm_data_rd  in  32  asynchronous read word.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP. The request is registered on acceptance (req_valid & req_ready).
- IDLE -> ISSUE on a legal, aligned request.
- IDLE -> RESP on an illegal or misaligned request. No memory cycle is issued; rsp_err is set.
- Legal funct3 for loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. For stores: 000 SB, 001 SH, 010 SW. Any other code is illegal (err 11). Illegal takes priority over misaligned.
- Misaligned: halfword with addr[0]=1; word with addr[1:0]≠0.
- Store mask: SB = 0001<<addr[1:0]; SH = 0011<<addr[1:0]; SW = 1111.
- Store data: SB = {4{wdata[7:0]}}; SH = {2{wdata[15:0]}}; SW = wdata.
- Load: select byte lane addr[1:0] or halfword lane addr[1]. LB/LH sign-extend; LBU/LHU zero-extend; LW is passed through.
- ISSUE (1 cycle): dm_cs=0, dm_stall=1, dm_addr/dm_mask valid. Store: dm_wr=0. Load: dm_wr=1. Always -> WAIT.
- WAIT:
  - Store: dm_cs=1, dm_wr=1.
  - Load: dm_cs=0, dm_wr=1, because read data is gated by cs.
  - On dm_valid=1: capture the extended dm_data_rd (load), go to RESP with err 00.
  - Cycle counter: increments each WAIT cycle. When it reaches TIMEOUT -> RESP with err 10, rdata 0.
- RESP: rsp_valid=1 for exactly 1 cycle -> IDLE. req_ready is low during RESP.
- Idle/default memory outputs: dm_cs=1, dm_wr=1, dm_mask=0, dm_addr=0, dm_data_wr=0, dm_stall=0.

## Timing
- Reset values: state IDLE, req_ready=1, rsp_valid=0, rsp_err=0, rsp_rdata=0, counter=0. All dm_* outputs take their idle values.
- Accepted at edge E0:
  - ISSUE is the cycle after E0.
  - WAIT is the next cycle; dm_valid is normally seen here.
  - RESP (rsp_valid=1) is the cycle after that. Nominal latency is 3 cycles accept-to-response.
- Error path: rsp_valid in the cycle after E0.
- Store write occurs on the memory's negedge inside ISSUE only. dm_cs=0 & dm_wr=0 never persists beyond one cycle.
- dm_valid arriving in ISSUE is ignored; only WAIT samples it.
- Throughput: one request per 4 cycles, or 2 cycles for errors. req_valid held during busy cycles is not accepted until IDLE.
- rst asserted mid-operation: all outputs return to reset values immediately (asynchronously). A store whose ISSUE negedge has not yet occurred is suppressed. No rsp_valid is produced for the aborted request.
- Counter width: $clog2(TIMEOUT+1). It is cleared on entering WAIT.

## Structure
- Package dm_access_pkg contains:
  - state enum (IDLE, ISSUE, WAIT, RESP);
  - funct3 localparams (LB, LH, LW, LBU, LHU, SB, SH, SW);
  - rsp_err codes (ERR_OK, ERR_MISALIGN, ERR_TIMEOUT, ERR_ILLEGAL).
- One combinational sub-module, dm_lane_align. It computes the illegal/misaligned flags, dm_mask, dm_data_wr, and extended load data from funct3, addr[1:0], wdata and rdata.
- The top level holds the FSM, request registers, timeout counter and response register.

## Test plan
- SW addr 0x10, wdata 0xDEADBEEF, then LW addr 0x10 -> ISSUE: dm_addr=4, dm_mask=1111. rsp_valid 3 cycles after accept; rsp_rdata=0xDEADBEEF, err 00.
- SB addr 0x13, wdata 0x000000A5 -> dm_mask=1000, dm_data_wr=0xA5A5A5A5. Then LB addr 0x13 -> rdata 0xFFFFFFA5; LBU -> 0x000000A5.
- SH addr 0x22, wdata 0x8001 -> dm_mask=1100. Then LH addr 0x22 -> 0xFFFF8001; LHU -> 0x00008001.
- LW addr 0x02, and separately SH funct3 011 -> no dm_cs assertion. rsp_valid 1 cycle after accept with err 01 and err 11 respectively.
- Memory model never raises dm_valid -> rsp_err=10 exactly TIMEOUT WAIT cycles after entering WAIT; rdata 0; req_ready high the next cycle.
- rst pulse during the WAIT of a load -> all dm_* outputs are idle immediately, no rsp_valid, req_ready=1 after release. A following LW completes normally.
